// File: rtl/pic_pkg.sv
// pic_pkg: shared opcode numbering, Q-phase encoding and instruction decoder for the PIC16F84 fetch/decode unit
package pic_pkg;
  localparam int PC_W_DEFAULT = 10;
  localparam logic [13:0] INSTR_NOP = 14'h0000;
  typedef enum logic [1:0] {Q1, Q2, Q3, Q4} qphase_e;
  localparam logic [4:0] OP_NOP = 5'd0, OP_GOTO = 5'd1, OP_CALL = 5'd2, OP_RETURN = 5'd3;
  localparam logic [4:0] OP_BCF = 5'd4, OP_BSF = 5'd5, OP_BTFSC = 5'd6, OP_MOVLW = 5'd7;
  localparam logic [4:0] OP_RETLW = 5'd8, OP_SUBLW = 5'd9, OP_ADDLW = 5'd10, OP_SUBWF = 5'd11;
  localparam logic [4:0] OP_DECF = 5'd12, OP_IORWF = 5'd13, OP_ANDWF = 5'd14, OP_XORWF = 5'd15;
  localparam logic [4:0] OP_ADDWF = 5'd16, OP_MOVF = 5'd17, OP_COMF = 5'd18, OP_INCF = 5'd19;
  localparam logic [4:0] OP_DECFSZ = 5'd20, OP_RRF = 5'd21, OP_RLF = 5'd22, OP_SWAPF = 5'd23;
  localparam logic [4:0] OP_INCFSZ = 5'd24, OP_IORLW = 5'd25, OP_ANDLW = 5'd26, OP_XORLW = 5'd27;
  localparam logic [4:0] OP_BTFSS = 5'd28, OP_CLRW = 5'd29, OP_MOVWF = 5'd30, OP_CLRF = 5'd31;
  typedef struct packed {
    logic [4:0] op;
    logic       ill;
  } dec_t;
  function automatic dec_t decode(input logic [13:0] i);
    dec_t d;
    d.op = OP_NOP;
    d.ill = 1'b0;
    case (i[13:12])
      2'b00: begin
        // byte ops 2..15 map linearly onto 11..24
        if (i[11:9] != 3'b000) d.op = 5'(i[11:8]) + 5'd9;
        else if (i[8]) d.op = i[7] ? OP_CLRF : OP_CLRW;
        else if (i[7]) d.op = OP_MOVWF;
        else if (i[6:1] == 6'b000100) d.op = OP_RETURN;
        else d.ill = !(i[4:0] == 5'd0 || i[6:0] == 7'h63 || i[6:0] == 7'h64);
      end
      2'b01: d.op = i[11] ? (i[10] ? OP_BTFSS : OP_BTFSC) : (i[10] ? OP_BSF : OP_BCF);
      2'b10: d.op = i[11] ? OP_GOTO : OP_CALL;
      default: begin
        d.ill = i[11:8] == 4'b1011;
        d.op = !i[11] ? (i[10] ? OP_RETLW : OP_MOVLW) :
               i[10] ? (i[9] ? OP_ADDLW : OP_SUBLW) :
               d.ill ? OP_NOP : i[9] ? OP_XORLW : i[8] ? OP_ANDLW : OP_IORLW;
      end
    endcase
    return d;
  endfunction
endpackage

// File: rtl/pic_return_stack.sv
// pic_return_stack: circular hardware return stack; ports clock, reset_n, push_i, pop_i, data_i -> data_o (top entry), stack_err_o when PIC_STACK_ERR_EN
module pic_return_stack #(
  parameter int W = 10,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
`ifdef PIC_STACK_ERR_EN
  , output logic       stack_err_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] sp_q, top;
  assign top = sp_q - 1'b1;
  assign data_o = mem_q[top];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sp_q <= '0;
    else sp_q <= push_i ? sp_q + 1'b1 : pop_i ? top : sp_q;
  always_ff @(posedge clock)
    if (push_i) mem_q[sp_q] <= data_i;
`ifdef PIC_STACK_ERR_EN
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW:0] live_q;
  logic err_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      live_q <= '0;
      err_q <= 1'b0;
    end else begin
      live_q <= push_i ? (live_q == FULL ? live_q : live_q + 1'b1) :
                pop_i ? (live_q == '0 ? live_q : live_q - 1'b1) : live_q;
      err_q <= err_q || (push_i && live_q == FULL) || (pop_i && live_q == '0);
    end
  assign stack_err_o = err_q;
`endif
endmodule

// File: rtl/pic_fetch_decode.sv
// pic_fetch_decode: PIC16F84 fetch/decode/sequencer; owns PC, Q1-Q4 phase and return stack
// Ports: clock, reset_n (async active-low), prog_data, skip_cond -> prog_addr, opcode, operand,
// alu_en, q_phase, illegal, plus sticky stack_err when PIC_STACK_ERR_EN is defined.
module pic_fetch_decode
  import pic_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT,
  parameter int STACK_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [13:0]     prog_data,
  input  logic            skip_cond,
  output logic [PC_W-1:0] prog_addr,
  output logic [4:0]      opcode,
  output logic [9:0]      operand,
  output logic            alu_en,
  output logic [1:0]      q_phase,
  output logic            illegal
`ifdef PIC_STACK_ERR_EN
  , output logic          stack_err
`endif
);
  qphase_e q_q;
  logic [PC_W-1:0] pc_q, pc_d, pop_data;
  logic [4:0] op_q, op_d;
  logic [9:0] opnd_q, opnd_d;
  logic ill_q, ill_d, q4, is_jump, is_ret, skip, flush;
  dec_t dec;
  // the executing instruction decides whether the word fetched alongside it is discarded
  always_comb begin
    dec = decode(prog_data);
    q4 = q_q == Q4;
    is_jump = op_q == OP_GOTO || op_q == OP_CALL;
    is_ret = op_q == OP_RETURN || op_q == OP_RETLW;
    skip = skip_cond && (op_q == OP_DECFSZ || op_q == OP_INCFSZ || op_q == OP_BTFSC || op_q == OP_BTFSS);
    flush = is_jump || is_ret || skip;
    pc_d = is_jump ? PC_W'(opnd_q) : is_ret ? pop_data : pc_q + 1'b1;
    op_d = flush ? OP_NOP : dec.op;
    opnd_d = flush ? '0 : prog_data[9:0];
    ill_d = !flush && dec.ill;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      q_q <= Q1;
      pc_q <= RESET_VECTOR;
      op_q <= OP_NOP;
      opnd_q <= INSTR_NOP[9:0];
      ill_q <= 1'b0;
    end else begin
      q_q <= qphase_e'(q_q + 2'd1);
      if (q4) begin
        pc_q <= pc_d;
        op_q <= op_d;
        opnd_q <= opnd_d;
        ill_q <= ill_d;
      end
    end
  pic_return_stack #(.W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clock(clock),
    .reset_n(reset_n),
    .push_i(q4 && op_q == OP_CALL),
    .pop_i(q4 && is_ret),
    .data_i(pc_q),
    .data_o(pop_data)
`ifdef PIC_STACK_ERR_EN
    , .stack_err_o(stack_err)
`endif
  );
  assign prog_addr = pc_q;
  assign opcode = op_q;
  assign operand = opnd_q;
  assign illegal = ill_q;
  assign q_phase = q_q;
  assign alu_en = q_q == Q3 && ((op_q >= OP_MOVLW && op_q <= OP_XORLW) || op_q == OP_CLRW || op_q == OP_MOVWF);
endmodule

// File: tb/tb_pic_fetch_decode.sv
// tb_pic_fetch_decode: directed self-checking bench for pic_fetch_decode
module tb_pic_fetch_decode;
  logic clock = 1'b0, reset_n = 1'b0, skip_cond = 1'b0;
  logic [13:0] prog_data;
  logic [9:0] prog_addr, operand;
  logic [4:0] opcode;
  logic [1:0] q_phase;
  logic alu_en, illegal;
`ifdef PIC_STACK_ERR_EN
  logic stack_err;
`endif
  logic [13:0] rom [1024];
  int total = 0, bad = 0;

  pic_fetch_decode dut (
    .clock(clock),
    .reset_n(reset_n),
    .prog_data(prog_data),
    .skip_cond(skip_cond),
    .prog_addr(prog_addr),
    .opcode(opcode),
    .operand(operand),
    .alu_en(alu_en),
    .q_phase(q_phase),
    .illegal(illegal)
`ifdef PIC_STACK_ERR_EN
    , .stack_err(stack_err)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) prog_data <= rom[prog_addr];

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    skip_cond = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // observe one instruction cycle starting in Q1; alu: 0 none, 1 single pulse in Q3, 2 anything else
  task automatic obs(output logic [4:0] op, output logic [9:0] od, output logic [9:0] pa,
                     output logic il, output int alu);
    int n = 0;
    logic in3 = 1'b0;
    op = opcode; od = operand; pa = prog_addr; il = illegal;
    for (int p = 0; p < 4; p++) begin
      if (alu_en === 1'b1) begin n++; in3 = (p == 2); end
      @(posedge clock); #1;
    end
    alu = n == 0 ? 0 : (n == 1 && in3) ? 1 : 2;
  endtask

  task automatic test_reset();
    clear_rom();
    rom[0] = 14'h305A;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (prog_addr !== 10'd0) begin bad++; $display("FAIL reset_pc got %h want 000", prog_addr); end
    total++; if ({q_phase, opcode, operand, alu_en, illegal} !== 19'd0)
      begin bad++; $display("FAIL reset_outs q=%0d op=%0d od=%h alu=%b il=%b want all 0", q_phase, opcode, operand, alu_en, illegal); end
    reset_n = 1'b1;
    for (int p = 0; p < 8; p++) begin
      total++; if (q_phase !== 2'(p)) begin bad++; $display("FAIL phase step%0d got %0d want %0d", p, q_phase, p % 4); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_movlw_goto();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    int eo [5] = '{0, 7, 1, 0, 25};
    int ed [5] = '{0, 'h05A, 'h100, 0, 'h022};
    int ep [5] = '{0, 1, 2, 'h100, 'h101};
    int ea [5] = '{0, 1, 0, 0, 1};
    clear_rom();
    rom[0] = 14'h305A; rom[1] = 14'h2900; rom[2] = 14'h3011; rom[10'h100] = 14'h3822;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'(eo[c])) begin bad++; $display("FAIL goto c%0d opcode got %0d want %0d", c, op, eo[c]); end
      total++; if (od !== 10'(ed[c])) begin bad++; $display("FAIL goto c%0d operand got %h want %h", c, od, ed[c]); end
      total++; if (pa !== 10'(ep[c])) begin bad++; $display("FAIL goto c%0d prog_addr got %h want %h", c, pa, ep[c]); end
      total++; if (alu !== ea[c]) begin bad++; $display("FAIL goto c%0d alu_en code got %0d want %0d", c, alu, ea[c]); end
    end
  endtask

  task automatic test_call_retlw();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    int eo [8] = '{0, 1, 0, 2, 0, 8, 0, 10};
    int ed [8] = '{0, 'h005, 0, 'h020, 0, 'h033, 0, 'h201};
    int ep [8] = '{0, 1, 5, 6, 'h020, 'h021, 6, 7};
    int ea [8] = '{0, 0, 0, 0, 0, 1, 0, 1};
    clear_rom();
    rom[0] = 14'h2805; rom[5] = 14'h2020; rom[6] = 14'h3E01; rom[10'h020] = 14'h3433; rom[10'h021] = 14'h3077;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'(eo[c])) begin bad++; $display("FAIL call c%0d opcode got %0d want %0d", c, op, eo[c]); end
      total++; if (od !== 10'(ed[c])) begin bad++; $display("FAIL call c%0d operand got %h want %h", c, od, ed[c]); end
      total++; if (pa !== 10'(ep[c])) begin bad++; $display("FAIL call c%0d prog_addr got %h want %h", c, pa, ep[c]); end
      total++; if (alu !== ea[c]) begin bad++; $display("FAIL call c%0d alu_en code got %0d want %0d", c, alu, ea[c]); end
    end
  endtask

  task automatic test_skip();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    int eo [7] = '{0, 20, 0, 7, 20, 7, 7};
    int ed [7] = '{0, 'h38C, 0, 'h022, 'h38C, 'h044, 'h055};
    int ep [7] = '{0, 1, 2, 3, 4, 5, 6};
    int ea [7] = '{0, 1, 0, 1, 1, 1, 1};
    clear_rom();
    rom[0] = 14'h0B8C; rom[1] = 14'h3011; rom[2] = 14'h3022;
    rom[3] = 14'h0B8C; rom[4] = 14'h3044; rom[5] = 14'h3055;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      skip_cond = (c == 1);
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'(eo[c])) begin bad++; $display("FAIL skip c%0d opcode got %0d want %0d", c, op, eo[c]); end
      total++; if (od !== 10'(ed[c])) begin bad++; $display("FAIL skip c%0d operand got %h want %h", c, od, ed[c]); end
      total++; if (pa !== 10'(ep[c])) begin bad++; $display("FAIL skip c%0d prog_addr got %h want %h", c, pa, ep[c]); end
      total++; if (alu !== ea[c]) begin bad++; $display("FAIL skip c%0d alu_en code got %0d want %0d", c, alu, ea[c]); end
    end
    skip_cond = 1'b0;
  endtask

  task automatic test_stack_wrap();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    clear_rom();
    for (int k = 0; k < 9; k++) begin
      rom[16 * k] = 14'h2000 | 14'(16 * (k + 1));
      rom[16 * k + 1] = 14'h0008;
    end
    rom[10'h090] = 14'h0008;
    do_reset();
    obs(op, od, pa, il, alu);
    for (int k = 0; k < 9; k++) begin
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'd2 || pa !== 10'(16 * k + 1))
        begin bad++; $display("FAIL call%0d opcode/addr got %0d/%h want 2/%h", k, op, pa, 16 * k + 1); end
      obs(op, od, pa, il, alu);
      total++; if (pa !== 10'(16 * (k + 1))) begin bad++; $display("FAIL call%0d target got %h want %h", k, pa, 16 * (k + 1)); end
`ifdef PIC_STACK_ERR_EN
      total++; if (stack_err !== (k == 8)) begin bad++; $display("FAIL stack_err after call%0d got %b want %b", k, stack_err, k == 8); end
`endif
    end
    for (int r = 0; r < 9; r++) begin
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'd3) begin bad++; $display("FAIL ret%0d opcode got %0d want 3", r, op); end
      obs(op, od, pa, il, alu);
      total++; if (pa !== (r < 8 ? 10'(8'h81 - 16 * r) : 10'h081))
        begin bad++; $display("FAIL ret%0d address got %h want %h", r, pa, r < 8 ? 8'h81 - 16 * r : 8'h81); end
    end
`ifdef PIC_STACK_ERR_EN
    total++; if (stack_err !== 1'b1) begin bad++; $display("FAIL stack_err sticky got %b want 1", stack_err); end
`endif
  endtask

  task automatic test_illegal();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    int eo [6] = '{0, 0, 30, 31, 0, 29};
    int ed [6] = '{0, 'h010, 'h08C, 'h18C, 'h300, 'h103};
    int el [6] = '{0, 1, 0, 0, 1, 0};
    int ea [6] = '{0, 0, 1, 0, 0, 1};
    clear_rom();
    rom[0] = 14'h0010; rom[1] = 14'h008C; rom[2] = 14'h018C; rom[3] = 14'h3B00; rom[4] = 14'h0103;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'(eo[c])) begin bad++; $display("FAIL illegal c%0d opcode got %0d want %0d", c, op, eo[c]); end
      total++; if (od !== 10'(ed[c])) begin bad++; $display("FAIL illegal c%0d operand got %h want %h", c, od, ed[c]); end
      total++; if (il !== 1'(el[c])) begin bad++; $display("FAIL illegal c%0d illegal got %b want %0d", c, il, el[c]); end
      total++; if (alu !== ea[c]) begin bad++; $display("FAIL illegal c%0d alu_en code got %0d want %0d", c, alu, ea[c]); end
      total++; if (pa !== 10'(c)) begin bad++; $display("FAIL illegal c%0d prog_addr got %h want %h", c, pa, c); end
    end
  endtask

  task automatic test_decode();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    logic [13:0] ins [14] = '{14'h0000, 14'h1000, 14'h1400, 14'h3C05, 14'h3E05, 14'h3905, 14'h3A05,
                              14'h0200, 14'h0F00, 14'h0E00, 14'h1800, 14'h1C00, 14'h0064, 14'h0063};
    int eo [14] = '{0, 4, 5, 9, 10, 26, 27, 11, 24, 23, 6, 28, 0, 0};
    int ea [14] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    clear_rom();
    for (int i = 0; i < 14; i++) rom[i] = ins[i];
    do_reset();
    obs(op, od, pa, il, alu);
    for (int c = 0; c < 14; c++) begin
      obs(op, od, pa, il, alu);
      total++; if (op !== 5'(eo[c]) || il !== 1'b0)
        begin bad++; $display("FAIL decode %h opcode/illegal got %0d/%b want %0d/0", ins[c], op, il, eo[c]); end
      total++; if (alu !== ea[c]) begin bad++; $display("FAIL decode %h alu_en code got %0d want %0d", ins[c], alu, ea[c]); end
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] op; logic [9:0] od, pa; logic il; int alu;
    clear_rom();
    rom[0] = 14'h305A; rom[1] = 14'h2900;
    do_reset();
    obs(op, od, pa, il, alu);
    @(posedge clock); #2;
    total++; if (opcode !== 5'd7 || q_phase !== 2'd1 || prog_addr !== 10'd1)
      begin bad++; $display("FAIL pre_reset op/q/pc got %0d/%0d/%h want 7/1/001", opcode, q_phase, prog_addr); end
    reset_n = 1'b0;
    #1;
    total++; if ({prog_addr, q_phase, opcode, operand, alu_en, illegal} !== 29'd0)
      begin bad++; $display("FAIL async_reset pc=%h q=%0d op=%0d od=%h alu=%b il=%b want all 0", prog_addr, q_phase, opcode, operand, alu_en, illegal); end
    @(negedge clock);
    reset_n = 1'b1;
    obs(op, od, pa, il, alu);
    total++; if (op !== 5'd0 || pa !== 10'd0) begin bad++; $display("FAIL restart flush op/pc got %0d/%h want 0/000", op, pa); end
    obs(op, od, pa, il, alu);
    total++; if (op !== 5'd7 || od !== 10'h05A || pa !== 10'd1)
      begin bad++; $display("FAIL restart movlw op/od/pc got %0d/%h/%h want 7/05a/001", op, od, pa); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_movlw_goto();
    test_call_retlw();
    test_skip();
    test_stack_wrap();
    test_illegal();
    test_decode();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
